// File: rtl/argmax_classifier.sv
// Argmax decision stage: captures one layer output vector and scans it serially,
// one element per cycle, reporting the index of the largest signed value.
// Optional macro ARGMAX_MAXVAL_EN exposes the winning value on o_maxval.
module argmax_classifier #(
  parameter int numInput  = 10,
  parameter int dataWidth = 16,
  parameter int idxWidth  = $clog2(numInput)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [numInput*dataWidth-1:0] i_data,
  input  logic                          i_valid,
  output logic [idxWidth-1:0]           o_data,
  output logic [dataWidth-1:0]          o_maxval,
  output logic                          o_valid,
  output logic                          o_busy
);

  // Handshake: i_valid is a one-cycle pulse accepted only in IDLE; o_valid is a
  // one-cycle pulse marking a fresh o_data/o_maxval, which then hold until the next.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]                    state_q, state_d;
  logic [idxWidth-1:0]           cnt_q, cnt_d;
  logic [idxWidth-1:0]           idx_q, idx_d;
  logic [dataWidth-1:0]          max_q, max_d;
  logic [idxWidth-1:0]           data_q, data_d;
  logic                          valid_q, valid_d;
  logic [numInput*dataWidth-1:0] buf_q;

  logic                 load;
  logic                 last;
  logic                 take;
  logic [dataWidth-1:0] cur;
  logic [dataWidth-1:0] nxt_max;
  logic [idxWidth-1:0]  nxt_idx;

  assign load    = (state_q == IDLE) && i_valid;
  assign cur     = buf_q[int'(cnt_q)*dataWidth +: dataWidth];
  assign take    = $signed(cur) > $signed(max_q);
  assign nxt_max = take ? cur : max_q;
  assign nxt_idx = take ? cnt_q : idx_q;
  assign last    = (cnt_q == idxWidth'(numInput - 1));

  // Data buffer needs no reset: it is only read while scanning a captured vector.
  always_ff @(posedge clk) begin
    if (load) buf_q <= i_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    max_d   = max_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d = SCAN;
          max_d   = i_data[dataWidth-1:0];
          idx_d   = '0;
          cnt_d   = idxWidth'(1);
        end
      end
      SCAN: begin
        max_d = nxt_max;
        idx_d = nxt_idx;
        cnt_d = cnt_q + idxWidth'(1);
        if (last) begin
          state_d = IDLE;
          cnt_d   = '0;
          data_d  = nxt_idx;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      max_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

`ifdef ARGMAX_MAXVAL_EN
  logic [dataWidth-1:0] maxval_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      maxval_q <= '0;
    end else if ((state_q == SCAN) && last) begin
      maxval_q <= nxt_max;
    end
  end

  assign o_maxval = maxval_q;
`else
  assign o_maxval = '0;
`endif

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_busy  = (state_q == SCAN);

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: a driver pushes expected decisions from an
// array-level argmax model; a negedge monitor pops and compares every output cycle.
module tb_argmax_classifier;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = $clog2(N);

  logic            clk;
  logic            rst;
  logic [N*DW-1:0] i_data;
  logic            i_valid;
  logic [IW-1:0]   o_data;
  logic [DW-1:0]   o_maxval;
  logic            o_valid;
  logic            o_busy;

  argmax_classifier #(.numInput(N), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .o_data(o_data), .o_maxval(o_maxval), .o_valid(o_valid), .o_busy(o_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard state
  logic [IW-1:0] exp_idx_q[$];
  logic [DW-1:0] exp_max_q[$];
  int            exp_cyc_q[$];
  int            neg_cnt  = 0;
  int            last_acc = -1000;
  logic [IW-1:0] held_idx = '0;
  logic [DW-1:0] held_max = '0;

  logic [DW-1:0] el[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, neg_cnt, act, exp);
    end
  endtask

  // reference: first index holding the largest signed value
  function automatic int ref_argmax();
    int best = 0;
    for (int i = 1; i < N; i++)
      if ($signed(el[i]) > $signed(el[best])) best = i;
    return best;
  endfunction

  // driver tasks
  task automatic send();
    int b;
    @(negedge clk); #1;
    for (int i = 0; i < N; i++) i_data[i*DW +: DW] = el[i];
    i_valid = 1'b1;
    if (neg_cnt >= last_acc + N) begin
      b = ref_argmax();
      last_acc = neg_cnt;
      exp_idx_q.push_back(IW'(b));
`ifdef ARGMAX_MAXVAL_EN
      exp_max_q.push_back(el[b]);
`else
      exp_max_q.push_back('0);
`endif
      exp_cyc_q.push_back(neg_cnt + N);
    end
    @(negedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_data", o_data, 0);
    chk("rst_maxval", o_maxval, 0);
    exp_idx_q.delete();
    exp_max_q.delete();
    exp_cyc_q.delete();
    last_acc = -1000;
    held_idx = '0;
    held_max = '0;
    idle(2);
    #1 rst = 1'b1;
  endtask

  // monitor
  always @(negedge clk) begin
    neg_cnt++;
    if (rst) begin
      chk("busy", o_busy, (neg_cnt > last_acc && neg_cnt <= last_acc + N - 1));
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == neg_cnt) begin
        chk("valid", o_valid, 1);
        void'(exp_cyc_q.pop_front());
        held_idx = exp_idx_q.pop_front();
        held_max = exp_max_q.pop_front();
      end else begin
        chk("valid", o_valid, 0);
      end
      chk("data", o_data, held_idx);
      chk("maxval", o_maxval, held_max);
    end
  end

  initial begin
    rst = 1'b0;
    i_valid = 1'b0;
    i_data = '0;
    idle(2);
    #1;
    chk("init_valid", o_valid, 0);
    chk("init_busy", o_busy, 0);
    chk("init_data", o_data, 0);
    chk("init_maxval", o_maxval, 0);
    rst = 1'b1;
    idle(2);

    // distinct values
    begin
      int v[N] = '{3, 7, 1, 9, 2, 0, 5, 4, 8, 6};
      for (int i = 0; i < N; i++) el[i] = DW'(v[i]);
    end
    send(); idle(12);

    // ties: lower index wins
    for (int i = 0; i < N; i++) el[i] = '0;
    el[2] = 16'h7FFF; el[6] = 16'h7FFF;
    send(); idle(12);

    // all negative, -1 wins
    for (int i = 0; i < N; i++) el[i] = 16'hFF9C;
    el[9] = 16'hFFFF;
    send(); idle(12);

    // max at index 0
    for (int i = 0; i < N; i++) el[i] = 16'd50;
    el[0] = 16'd100;
    send(); idle(12);

    // busy: second pulse mid-scan ignored, third in o_valid cycle accepted
    for (int i = 0; i < N; i++) el[i] = DW'(i);
    send();
    for (int i = 0; i < N; i++) el[i] = DW'(N - i);
    idle(2); send();
    for (int i = 0; i < N; i++) el[i] = DW'(i * 3 % 7);
    idle(4); send();
    idle(12);

    // reset mid-scan, then a fresh decision
    for (int i = 0; i < N; i++) el[i] = DW'(i + 1);
    send(); idle(3);
    do_reset();
    idle(12);
    for (int i = 0; i < N; i++) el[i] = DW'(20 - i);
    el[4] = 16'd200;
    send(); idle(12);

    // randomized, narrow ranges force ties and sign mixes
    for (int t = 0; t < 40; t++) begin
      int mode = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) begin
        if (mode == 0) el[i] = DW'($urandom);
        else if (mode == 1) el[i] = DW'($urandom_range(0, 3));
        else el[i] = DW'($signed($urandom_range(0, 6)) - 3);
      end
      send();
      idle($urandom_range(0, 12));
    end
    idle(15);

    checks++;
    if (exp_cyc_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d decisions outstanding, expected 0", exp_cyc_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
